// File: rtl/matrix_store_v2.sv
// Matrix storage with per-shape round-robin slot allocation, streamed fills
// and NUM_RD independent registered read ports.
module matrix_store_v2 #(
  parameter int DATA_W        = 8,
  parameter int MAX_ROWS      = 5,
  parameter int MAX_COLS      = 5,
  parameter int SLOTS_PER_DIM = 4,
  parameter int NUM_RD        = 2,
  localparam int SLOT_W = $clog2(MAX_ROWS*MAX_COLS*SLOTS_PER_DIM),
  localparam int RW     = $clog2(MAX_ROWS+1),
  localparam int CW     = $clog2(MAX_COLS+1),
  localparam int LW     = $clog2(SLOTS_PER_DIM+1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_wr,
  input  logic [LW-1:0]            cfg_limit,
  input  logic                     alloc_req,
  input  logic [RW-1:0]            alloc_rows,
  input  logic [CW-1:0]            alloc_cols,
  output logic                     alloc_ready,
  output logic                     alloc_done,
  output logic                     alloc_err,
  output logic [SLOT_W-1:0]        alloc_slot,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     fill_done,
  input  logic                     abort,
  input  logic                     clr_en,
  input  logic [SLOT_W-1:0]        clr_slot,
  input  logic [NUM_RD*SLOT_W-1:0] rd_slot,
  input  logic [NUM_RD*RW-1:0]     rd_row,
  input  logic [NUM_RD*CW-1:0]     rd_col,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD*RW-1:0]     rd_rows,
  output logic [NUM_RD*CW-1:0]     rd_cols,
  output logic [NUM_RD-1:0]        rd_vld
);

  localparam int NUM_SHAPES = MAX_ROWS * MAX_COLS;
  localparam int NUM_SLOTS  = NUM_SHAPES * SLOTS_PER_DIM;
  localparam int ELEMS      = MAX_ROWS * MAX_COLS;
  localparam int DEPTH      = NUM_SLOTS * ELEMS;
  localparam int AW         = $clog2(DEPTH);
  localparam int SHW        = (NUM_SHAPES > 1) ? $clog2(NUM_SHAPES) : 1;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t              state_reg;
  logic                alloc_done_reg;
  logic                alloc_err_reg;
  logic [SLOT_W-1:0]   alloc_slot_reg;
  logic [SLOT_W-1:0]   fill_slot_reg;
  logic [RW-1:0]       fill_rows_reg;
  logic [CW-1:0]       fill_cols_reg;
  logic [RW-1:0]       row_reg;
  logic [CW-1:0]       col_reg;
  logic [LW-1:0]       limit_reg;
  logic [LW-1:0]       ptr_reg  [NUM_SHAPES];
  logic [LW-1:0]       ptr_next [NUM_SHAPES];
  logic                valid_reg [NUM_SLOTS];
  logic [RW-1:0]       rows_reg  [NUM_SLOTS];
  logic [CW-1:0]       cols_reg  [NUM_SLOTS];
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                alloc_legal;
  logic                alloc_fire;
  logic [SHW-1:0]      shape_idx;
  logic [LW-1:0]       alloc_ptr;
  logic [LW-1:0]       ptr_inc;
  logic [SLOT_W-1:0]   new_slot;
  logic [LW-1:0]       limit_new;
  logic                clr_hit;
  logic                clr_kill;
  logic                wr_en;
  logic                last_elem;
  logic                fill_last;
  logic [AW-1:0]       wr_addr;

  always_comb begin
    alloc_legal = (alloc_rows != '0) && (alloc_rows <= RW'(MAX_ROWS)) &&
                  (alloc_cols != '0) && (alloc_cols <= CW'(MAX_COLS));
    shape_idx = '0;
    if (alloc_legal)
      shape_idx = SHW'((int'(alloc_rows) - 1) * MAX_COLS + int'(alloc_cols) - 1);
    alloc_ptr  = ptr_reg[shape_idx];
    ptr_inc    = (alloc_ptr + LW'(1) == limit_reg) ? '0 : alloc_ptr + LW'(1);
    new_slot   = SLOT_W'(int'(shape_idx) * SLOTS_PER_DIM + int'(alloc_ptr));
    alloc_fire = (state_reg == IDLE) && alloc_req && alloc_legal;

    if (cfg_limit == '0)
      limit_new = LW'(1);
    else if (cfg_limit > LW'(SLOTS_PER_DIM))
      limit_new = LW'(SLOTS_PER_DIM);
    else
      limit_new = cfg_limit;

    clr_hit   = clr_en && (int'(clr_slot) < NUM_SLOTS);
    clr_kill  = clr_hit && (state_reg == FILL) && (clr_slot == fill_slot_reg);
    // A clear of the slot being filled drops the element offered that cycle.
    wr_en     = (state_reg == FILL) && in_valid && !clr_kill;
    last_elem = (row_reg == fill_rows_reg - RW'(1)) && (col_reg == fill_cols_reg - CW'(1));
    fill_last = wr_en && last_elem;
    wr_addr   = AW'(int'(fill_slot_reg) * ELEMS + int'(row_reg) * MAX_COLS + int'(col_reg));
  end

  // Config clamp applies after the allocation step so a shrinking limit wins.
  always_comb begin
    for (int s = 0; s < NUM_SHAPES; s++) begin
      ptr_next[s] = ptr_reg[s];
      if (alloc_fire && (shape_idx == SHW'(s)))
        ptr_next[s] = ptr_inc;
      if (cfg_wr && (ptr_next[s] >= limit_new))
        ptr_next[s] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit_reg <= LW'(SLOTS_PER_DIM);
      for (int s = 0; s < NUM_SHAPES; s++)
        ptr_reg[s] <= '0;
    end else begin
      if (cfg_wr)
        limit_reg <= limit_new;
      for (int s = 0; s < NUM_SHAPES; s++)
        ptr_reg[s] <= ptr_next[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        valid_reg[s] <= 1'b0;
        rows_reg[s]  <= '0;
        cols_reg[s]  <= '0;
      end
    end else begin
      if (alloc_fire) begin
        valid_reg[new_slot] <= 1'b1;
        rows_reg[new_slot]  <= alloc_rows;
        cols_reg[new_slot]  <= alloc_cols;
      end
      if (clr_hit)
        valid_reg[clr_slot] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      alloc_done_reg <= 1'b0;
      alloc_err_reg  <= 1'b0;
      alloc_slot_reg <= '0;
      fill_slot_reg  <= '0;
      fill_rows_reg  <= '0;
      fill_cols_reg  <= '0;
      row_reg        <= '0;
      col_reg        <= '0;
    end else begin
      alloc_done_reg <= 1'b0;
      alloc_err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (alloc_req) begin
            if (alloc_legal) begin
              alloc_slot_reg <= new_slot;
              alloc_done_reg <= 1'b1;
              fill_slot_reg  <= new_slot;
              fill_rows_reg  <= alloc_rows;
              fill_cols_reg  <= alloc_cols;
              row_reg        <= '0;
              col_reg        <= '0;
              state_reg      <= FILL;
            end else begin
              alloc_err_reg <= 1'b1;
            end
          end
        end
        FILL: begin
          if (clr_kill || abort || fill_last) begin
            state_reg <= IDLE;
          end else if (wr_en) begin
            if (col_reg == fill_cols_reg - CW'(1)) begin
              col_reg <= '0;
              row_reg <= row_reg + RW'(1);
            end else begin
              col_reg <= col_reg + CW'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= in_data;
  end

  assign alloc_ready = (state_reg == IDLE);
  assign in_ready    = (state_reg == FILL);
  assign alloc_done  = alloc_done_reg;
  assign alloc_err   = alloc_err_reg;
  assign alloc_slot  = alloc_slot_reg;
  assign fill_done   = fill_last;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] slot_idx;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic              slot_ok;
    logic              in_range;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data_reg;
    logic [RW-1:0]     rows_q_reg;
    logic [CW-1:0]     cols_q_reg;
    logic              vld_reg;

    assign slot     = rd_slot[gi*SLOT_W +: SLOT_W];
    assign row      = rd_row[gi*RW +: RW];
    assign col      = rd_col[gi*CW +: CW];
    assign slot_ok  = int'(slot) < NUM_SLOTS;
    assign slot_idx = slot_ok ? slot : '0;
    assign in_range = (row < rows_reg[slot_idx]) && (col < cols_reg[slot_idx]);
    assign addr     = AW'(int'(slot_idx) * ELEMS + int'(row) * MAX_COLS + int'(col));

    // Same-edge reads see the pre-write RAM contents.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_reg   <= '0;
        rows_q_reg <= '0;
        cols_q_reg <= '0;
        vld_reg    <= 1'b0;
      end else if (!slot_ok) begin
        data_reg   <= '0;
        rows_q_reg <= '0;
        cols_q_reg <= '0;
        vld_reg    <= 1'b0;
      end else begin
        rows_q_reg <= rows_reg[slot_idx];
        cols_q_reg <= cols_reg[slot_idx];
        vld_reg    <= valid_reg[slot_idx];
        if (valid_reg[slot_idx] && in_range)
          data_reg <= mem[addr];
        else
          data_reg <= '0;
      end
    end

    assign rd_data[gi*DATA_W +: DATA_W] = data_reg;
    assign rd_rows[gi*RW +: RW]         = rows_q_reg;
    assign rd_cols[gi*CW +: CW]         = cols_q_reg;
    assign rd_vld[gi]                   = vld_reg;
  end

endmodule

// File: tb/tb_matrix_store_v2.sv
// Directed bench for matrix_store_v2: vector tables for allocation and reads,
// hand sequences for config, abort, clear, read-before-write and async reset.
module tb_matrix_store_v2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_wr;
  logic [2:0]  cfg_limit;
  logic        alloc_req;
  logic [2:0]  alloc_rows;
  logic [2:0]  alloc_cols;
  logic        alloc_ready;
  logic        alloc_done;
  logic        alloc_err;
  logic [6:0]  alloc_slot;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        fill_done;
  logic        abort;
  logic        clr_en;
  logic [6:0]  clr_slot;
  logic [13:0] rd_slot;
  logic [5:0]  rd_row;
  logic [5:0]  rd_col;
  logic [15:0] rd_data;
  logic [5:0]  rd_rows;
  logic [5:0]  rd_cols;
  logic [1:0]  rd_vld;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    int         port;
    int         slot;
    int         row;
    int         col;
    logic [7:0] data;
    logic       vld;
    int         rows;
    int         cols;
  } rd_vec_t;

  typedef struct {
    int         rows;
    int         cols;
    logic       err;
    int         slot;
  } al_vec_t;

  rd_vec_t rv [6];
  al_vec_t av [6];

  always #5 clk = ~clk;

  matrix_store_v2 dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr(cfg_wr), .cfg_limit(cfg_limit),
    .alloc_req(alloc_req), .alloc_rows(alloc_rows), .alloc_cols(alloc_cols),
    .alloc_ready(alloc_ready), .alloc_done(alloc_done), .alloc_err(alloc_err),
    .alloc_slot(alloc_slot),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fill_done(fill_done), .abort(abort),
    .clr_en(clr_en), .clr_slot(clr_slot),
    .rd_slot(rd_slot), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data), .rd_rows(rd_rows), .rd_cols(rd_cols), .rd_vld(rd_vld)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", nm, act);
    end
  endtask

  task automatic do_alloc(input int r, input int c);
    alloc_req  = 1'b1;
    alloc_rows = r[2:0];
    alloc_cols = c[2:0];
    tick();
    alloc_req  = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic exp_done);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    chk("fill_done", fill_done, exp_done);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic do_cfg(input int v);
    cfg_wr    = 1'b1;
    cfg_limit = v[2:0];
    tick();
    cfg_wr    = 1'b0;
  endtask

  task automatic set_rd(input int p, input int s, input int r, input int c);
    rd_slot[p*7 +: 7] = s[6:0];
    rd_row[p*3 +: 3]  = r[2:0];
    rd_col[p*3 +: 3]  = c[2:0];
  endtask

  task automatic chk_rd(input int p, input string nm, input int d, input int v,
                        input int r, input int c);
    chk({nm, ".data"}, rd_data[p*8 +: 8], d[7:0]);
    chk({nm, ".vld"},  rd_vld[p],         v[0]);
    chk({nm, ".rows"}, rd_rows[p*3 +: 3], r[2:0]);
    chk({nm, ".cols"}, rd_cols[p*3 +: 3], c[2:0]);
  endtask

  initial begin
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_limit = '0; alloc_req = 1'b0;
    alloc_rows = '0; alloc_cols = '0; in_valid = 1'b0; in_data = '0;
    abort = 1'b0; clr_en = 1'b0; clr_slot = '0;
    rd_slot = '0; rd_row = '0; rd_col = '0;

    rv[0] = '{0, 28, 1, 2, 8'd6, 1'b1, 2, 3};
    rv[1] = '{1, 28, 0, 0, 8'd1, 1'b1, 2, 3};
    rv[2] = '{0, 28, 0, 2, 8'd3, 1'b1, 2, 3};
    rv[3] = '{1, 28, 1, 0, 8'd4, 1'b1, 2, 3};
    rv[4] = '{0, 28, 5, 0, 8'd0, 1'b1, 2, 3};
    rv[5] = '{1, 29, 0, 0, 8'd0, 1'b0, 0, 0};

    av[0] = '{0, 3, 1'b1, 0};
    av[1] = '{6, 1, 1'b1, 0};
    av[2] = '{5, 5, 1'b0, 96};
    av[3] = '{3, 0, 1'b1, 0};
    av[4] = '{1, 2, 1'b0, 4};
    av[5] = '{0, 0, 1'b1, 0};

    // Reset values
    #12;
    chk("rst.alloc_ready", alloc_ready, 1);
    chk("rst.in_ready",    in_ready,    0);
    chk("rst.alloc_done",  alloc_done,  0);
    chk("rst.alloc_err",   alloc_err,   0);
    chk("rst.alloc_slot",  alloc_slot,  0);
    chk("rst.fill_done",   fill_done,   0);
    chk("rst.rd_vld",      rd_vld,      0);
    chk("rst.rd_data",     rd_data,     0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // 2x3 allocation and fill with 1..6
    do_alloc(2, 3);
    chk("a23.done",  alloc_done,  1);
    chk("a23.slot",  alloc_slot,  28);
    chk("a23.in_ready", in_ready, 1);
    chk("a23.alloc_ready", alloc_ready, 0);
    for (int i = 1; i <= 6; i++) begin
      push(8'(i), (i == 6));
      if (i == 1) chk("a23.done_pulse", alloc_done, 0);
    end
    chk("a23.idle_ready", alloc_ready, 1);
    chk("a23.idle_in_ready", in_ready, 0);

    for (int i = 0; i < 6; i++) begin
      set_rd(rv[i].port, rv[i].slot, rv[i].row, rv[i].col);
      tick();
      chk_rd(rv[i].port, $sformatf("rdvec%0d", i), int'(rv[i].data), int'(rv[i].vld),
             rv[i].rows, rv[i].cols);
    end

    // Allocation vectors: illegal dims and first-pointer slots
    for (int i = 0; i < 6; i++) begin
      do_alloc(av[i].rows, av[i].cols);
      chk($sformatf("alvec%0d.err", i),  alloc_err,  av[i].err);
      chk($sformatf("alvec%0d.done", i), alloc_done, !av[i].err);
      if (!av[i].err) begin
        chk($sformatf("alvec%0d.slot", i), alloc_slot, av[i].slot);
        do_abort();
      end else begin
        chk($sformatf("alvec%0d.ready", i), alloc_ready, 1);
      end
      chk($sformatf("alvec%0d.in_ready", i), in_ready, 0);
    end

    // Limit 2: 1x1 round-robin 0,1,0
    do_cfg(2);
    do_alloc(1, 1); chk("rr0.slot", alloc_slot, 0); push(8'h11, 1'b1);
    do_alloc(1, 1); chk("rr1.slot", alloc_slot, 1); push(8'h22, 1'b1);
    do_alloc(1, 1); chk("rr2.slot", alloc_slot, 0); push(8'h33, 1'b1);
    set_rd(0, 0, 0, 0);
    set_rd(1, 1, 0, 0);
    tick();
    chk_rd(0, "rr.slot0", 8'h33, 1, 1, 1);
    chk_rd(1, "rr.slot1", 8'h22, 1, 1, 1);

    // Clamp high (7 -> 4) keeps pointer; clamp low (0 -> 1) zeroes it
    do_cfg(7);
    do_alloc(1, 1); chk("clamp_hi.slot", alloc_slot, 1); do_abort();
    do_cfg(0);
    do_alloc(1, 1); chk("clamp_lo.slot_a", alloc_slot, 0); do_abort();
    do_alloc(1, 1); chk("clamp_lo.slot_b", alloc_slot, 0); do_abort();
    do_cfg(4);

    // 3x3 partial fill with gaps, ignored alloc in FILL, then abort
    do_alloc(3, 3);
    chk("a33.slot", alloc_slot, 48);
    push(8'd10, 1'b0);
    alloc_req = 1'b1; alloc_rows = 3'd1; alloc_cols = 3'd1;
    tick();
    alloc_req = 1'b0;
    chk("a33.alloc_ignored", alloc_done, 0);
    push(8'd20, 1'b0);
    tick(); tick();
    push(8'd30, 1'b0);
    tick();
    push(8'd40, 1'b0);
    do_abort();
    chk("a33.abort_in_ready", in_ready, 0);
    chk("a33.abort_ready", alloc_ready, 1);
    set_rd(0, 48, 1, 0);
    set_rd(1, 48, 0, 1);
    tick();
    chk_rd(0, "a33.r10", 8'd40, 1, 3, 3);
    chk_rd(1, "a33.r01", 8'd20, 1, 3, 3);

    // Read-before-write on port0, independent read on port1
    do_alloc(2, 3);
    chk("rbw.slot", alloc_slot, 28);
    set_rd(0, 28, 0, 0);
    set_rd(1, 0, 0, 0);
    in_valid = 1'b1; in_data = 8'hFB;
    tick();
    in_valid = 1'b0;
    chk_rd(0, "rbw.old", 1, 1, 2, 3);
    chk_rd(1, "rbw.port1", 8'h33, 1, 1, 1);
    tick();
    chk_rd(0, "rbw.new", 8'hFB, 1, 2, 3);

    // Clear the slot being filled while an element is offered
    clr_en = 1'b1; clr_slot = 7'd28;
    in_valid = 1'b1; in_data = 8'h55;
    #1;
    chk("clr.fill_done", fill_done, 0);
    tick();
    clr_en = 1'b0; in_valid = 1'b0;
    chk("clr.in_ready", in_ready, 0);
    chk("clr.alloc_ready", alloc_ready, 1);
    set_rd(0, 28, 0, 0);
    tick();
    chk_rd(0, "clr.read", 0, 0, 2, 3);

    // Out-of-range clear is ignored; in-range clear in IDLE invalidates
    clr_en = 1'b1; clr_slot = 7'd120;
    set_rd(0, 48, 1, 0);
    tick();
    clr_en = 1'b0;
    tick();
    chk_rd(0, "clr_oor.read", 8'd40, 1, 3, 3);
    clr_en = 1'b1; clr_slot = 7'd1;
    tick();
    clr_en = 1'b0;
    set_rd(0, 1, 0, 0);
    tick();
    chk_rd(0, "clr_idle.read", 0, 0, 1, 1);

    // Abort coinciding with the last element
    do_alloc(1, 1);
    chk("abl.slot", alloc_slot, 0);
    in_valid = 1'b1; in_data = 8'h77; abort = 1'b1;
    #1;
    chk("abl.fill_done", fill_done, 1);
    tick();
    in_valid = 1'b0; abort = 1'b0;
    chk("abl.in_ready", in_ready, 0);
    set_rd(0, 0, 0, 0);
    tick();
    chk_rd(0, "abl.read", 8'h77, 1, 1, 1);

    // Asynchronous reset in the middle of a fill
    do_alloc(2, 2);
    chk("arst.slot", alloc_slot, 24);
    push(8'h99, 1'b0);
    chk("arst.pre_in_ready", in_ready, 1);
    chk("arst.pre_vld", rd_vld[0], 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.in_ready",    in_ready,    0);
    chk("arst.alloc_ready", alloc_ready, 1);
    chk("arst.alloc_slot",  alloc_slot,  0);
    chk("arst.rd_vld",      rd_vld,      0);
    chk("arst.rd_data",     rd_data,     0);
    tick();
    rst_n = 1'b1;
    set_rd(0, 24, 0, 0);
    set_rd(1, 0, 0, 0);
    tick();
    chk_rd(0, "arst.slot24", 0, 0, 0, 0);
    chk_rd(1, "arst.slot0", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
